// File: rtl/accel_pkg.sv
// Shared state encoding and transaction constants for the accelerometer SPI reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package accel_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        UPDATE
    } state_e;

    localparam logic [7:0] CMD_WRITE     = 8'h0A;
    localparam logic [7:0] REG_POWER_CTL = 8'h2D;
    localparam logic [7:0] PWR_MEASURE   = 8'h02;
    localparam logic [5:0] READ_BITS     = 6'd32;
    localparam logic [5:0] INIT_BITS     = 6'd24;

endpackage

// File: rtl/spi_bit_engine.sv
// SPI mode-0 bit engine: SCLK divider, MSB-first MOSI shifter, MISO capture of the last 16 bits.
// Latency: done pulses one cycle after the final SCLK falling edge (2*CLK_DIV cycles per bit).
// Backpressure: none; start is only honoured when the caller knows the engine is idle.
module spi_bit_engine #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    input  logic [5:0]  nbits,
    input  logic [31:0] tx,
    input  logic        miso,
    output logic        sclk,
    output logic        mosi,
    output logic        done,
    output logic [15:0] rx
);
    localparam int DW = $clog2(CLK_DIV);

    logic          busy;
    logic [DW-1:0] div_cnt;
    logic [5:0]    bits_left;
    logic [31:0]   tx_sh;
    logic          half_end;

    assign half_end = busy && (div_cnt == DW'(CLK_DIV - 1));
    assign mosi     = tx_sh[31];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            busy      <= 1'b0;
            div_cnt   <= '0;
            bits_left <= '0;
            tx_sh     <= '0;
            sclk      <= 1'b0;
            done      <= 1'b0;
            rx        <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy      <= 1'b1;
                div_cnt   <= '0;
                sclk      <= 1'b0;
                bits_left <= nbits;
                tx_sh     <= tx;
            end else if (busy) begin
                if (half_end) begin
                    div_cnt <= '0;
                    sclk    <= ~sclk;
                    // Rising edge samples MISO; falling edge advances MOSI or ends the burst.
                    if (!sclk) begin
                        rx <= {rx[14:0], miso};
                    end else if (bits_left == 6'd1) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        tx_sh <= '0;
                    end else begin
                        bits_left <= bits_left - 6'd1;
                        tx_sh     <= {tx_sh[30:0], 1'b0};
                    end
                end else begin
                    div_cnt <= div_cnt + DW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/accel_spi_reader.sv
// Polls X/Y accelerometer samples over SPI mode 0; macro ACCEL_INIT_EN adds a POWER_CTL write after reset.
// Latency: CS fall to o_valid is 66*CLK_DIV+1 cycles; next poll launches POLL_PERIOD idle cycles later.
// Backpressure: none downstream; i_pause only defers the start of the next transaction.
module accel_spi_reader
    import accel_pkg::*;
#(
    parameter int         CLK_DIV     = 4,
    parameter int         POLL_PERIOD = 50000,
    parameter logic [7:0] READ_CMD    = 8'h0B,
    parameter logic [7:0] X_ADDR      = 8'h08
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       i_pause,
    input  logic       i_miso,
    output logic       o_sclk,
    output logic       o_mosi,
    output logic       o_cs_n,
    output logic [7:0] o_accel_x,
    output logic [7:0] o_accel_y,
    output logic       o_valid
);
    localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int WW = $clog2(CLK_DIV);

    state_e        state, nxt;
    logic [PW-1:0] poll_cnt;
    logic [WW-1:0] wait_cnt;
    logic          wait_end;
    logic          wr_phase;
    logic          start;
    logic [5:0]    nbits;
    logic [31:0]   tx_word;
    logic          eng_sclk, eng_mosi, eng_done;
    logic [15:0]   eng_rx;

`ifdef ACCEL_INIT_EN
    localparam state_e RST_STATE = INIT;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_phase <= 1'b1;
        end else if (state == CS_HOLD && nxt == IDLE) begin
            wr_phase <= 1'b0;
        end
    end
`else
    localparam state_e RST_STATE = IDLE;

    assign wr_phase = 1'b0;
`endif

    assign wait_end = (wait_cnt == WW'(CLK_DIV - 1));
    assign tx_word  = wr_phase ? {CMD_WRITE, REG_POWER_CTL, PWR_MEASURE, 8'h00}
                               : {READ_CMD, X_ADDR, 16'h0000};
    assign nbits    = wr_phase ? INIT_BITS : READ_BITS;
    assign o_sclk   = eng_sclk;
    // The engine only loads its shifter on start, so present the first bit during CS setup.
    assign o_mosi   = (state == CS_SETUP) ? tx_word[31] : eng_mosi;

    always_comb begin
        nxt   = state;
        start = 1'b0;
        case (state)
`ifdef ACCEL_INIT_EN
            INIT:     nxt = CS_SETUP;
`endif
            IDLE:     if (!i_pause && poll_cnt == PW'(POLL_PERIOD - 1)) nxt = CS_SETUP;
            CS_SETUP: if (wait_end) begin
                          start = 1'b1;
                          nxt   = SHIFT;
                      end
            SHIFT:    if (eng_done) nxt = CS_HOLD;
            CS_HOLD:  if (wait_end) nxt = wr_phase ? IDLE : UPDATE;
            UPDATE:   nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= RST_STATE;
            poll_cnt  <= '0;
            wait_cnt  <= '0;
            o_cs_n    <= 1'b1;
            o_valid   <= 1'b0;
            o_accel_x <= '0;
            o_accel_y <= '0;
        end else begin
            state <= nxt;
            if (nxt != state) begin
                wait_cnt <= '0;
            end else if (state == CS_SETUP || state == CS_HOLD) begin
                wait_cnt <= wait_cnt + WW'(1);
            end
            if (state == IDLE && !i_pause) begin
                poll_cnt <= (nxt == CS_SETUP) ? '0 : poll_cnt + PW'(1);
            end
            o_cs_n  <= !(nxt == CS_SETUP || nxt == SHIFT || nxt == CS_HOLD);
            o_valid <= (nxt == UPDATE);
            // Publish both samples together, only from a fully completed read.
            if (state == CS_HOLD && nxt == UPDATE) begin
                o_accel_x <= eng_rx[15:8];
                o_accel_y <= eng_rx[7:0];
            end
        end
    end

    spi_bit_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .clk    (clk),
        .arst_n (arst_n),
        .start  (start),
        .nbits  (nbits),
        .tx     (tx_word),
        .miso   (i_miso),
        .sclk   (eng_sclk),
        .mosi   (eng_mosi),
        .done   (eng_done),
        .rx     (eng_rx)
    );

endmodule
